// File: rtl/register_file.sv
// rtl/register_file.sv - architectural register file with ROB rename tags and commit forwarding
// Per-register value, busy bit and owning ROB tag; x0 is hardwired to zero.
module register_file #(
  parameter int REG_NUM = 32,
  parameter int ROB_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             flush,
  input  logic             update_valid,
  input  logic [ROB_W-1:0] update_pos,
  input  logic [4:0]       update_rd,
  input  logic             commit_valid,
  input  logic [ROB_W-1:0] commit_pos,
  input  logic [4:0]       commit_dest,
  input  logic [31:0]      commit_value,
  input  logic [4:0]       rs1_addr,
  input  logic [4:0]       rs2_addr,
  output logic             rs1_busy,
  output logic             rs2_busy,
  output logic [31:0]      rs1_val,
  output logic [31:0]      rs2_val,
  output logic [ROB_W-1:0] rs1_rob_pos,
  output logic [ROB_W-1:0] rs2_rob_pos
);

  logic [31:0]      value_q [REG_NUM];
  logic             busy_q  [REG_NUM];
  logic [ROB_W-1:0] tag_q   [REG_NUM];

  logic commit_en;
  logic update_en;
  logic hit1;
  logic hit2;

  assign commit_en = commit_valid && (commit_dest != 5'd0);
  assign update_en = update_valid && (update_rd != 5'd0);

  // Rename is applied after the commit clear so a same-cycle rename of the same rd wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) begin
        value_q[i] <= '0;
        busy_q[i]  <= 1'b0;
        tag_q[i]   <= '0;
      end
    end else if (rdy) begin
      if (flush) begin
        for (int i = 0; i < REG_NUM; i++) begin
          busy_q[i] <= 1'b0;
          tag_q[i]  <= '0;
        end
      end else begin
        if (commit_en) begin
          value_q[commit_dest] <= commit_value;
          if (busy_q[commit_dest] && (tag_q[commit_dest] == commit_pos))
            busy_q[commit_dest] <= 1'b0;
        end
        if (update_en) begin
          busy_q[update_rd] <= 1'b1;
          tag_q[update_rd]  <= update_pos;
        end
      end
    end
  end

  // Forward only when the retiring entry is still the current owner of the source.
  assign hit1 = commit_en && !flush && (commit_dest == rs1_addr) &&
                busy_q[rs1_addr] && (tag_q[rs1_addr] == commit_pos);
  assign hit2 = commit_en && !flush && (commit_dest == rs2_addr) &&
                busy_q[rs2_addr] && (tag_q[rs2_addr] == commit_pos);

  always_comb begin
    rs1_busy    = 1'b0;
    rs1_val     = '0;
    rs1_rob_pos = '0;
    if (rs1_addr != 5'd0) begin
      rs1_busy    = hit1 ? 1'b0 : busy_q[rs1_addr];
      rs1_val     = hit1 ? commit_value : value_q[rs1_addr];
      rs1_rob_pos = tag_q[rs1_addr];
    end
  end

  always_comb begin
    rs2_busy    = 1'b0;
    rs2_val     = '0;
    rs2_rob_pos = '0;
    if (rs2_addr != 5'd0) begin
      rs2_busy    = hit2 ? 1'b0 : busy_q[rs2_addr];
      rs2_val     = hit2 ? commit_value : value_q[rs2_addr];
      rs2_rob_pos = tag_q[rs2_addr];
    end
  end

endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - directed self-checking bench for register_file
// Inputs change 1 ns after posedge; outputs are checked mid-cycle.
module tb_register_file;

  logic        clk = 1'b0;
  logic        rst, rdy, flush;
  logic        update_valid;
  logic [3:0]  update_pos;
  logic [4:0]  update_rd;
  logic        commit_valid;
  logic [3:0]  commit_pos;
  logic [4:0]  commit_dest;
  logic [31:0] commit_value;
  logic [4:0]  rs1_addr, rs2_addr;
  logic        rs1_busy, rs2_busy;
  logic [31:0] rs1_val, rs2_val;
  logic [3:0]  rs1_rob_pos, rs2_rob_pos;

  int n_checks = 0;
  int n_fail   = 0;

  register_file #(.REG_NUM(32), .ROB_W(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .update_valid(update_valid), .update_pos(update_pos), .update_rd(update_rd),
    .commit_valid(commit_valid), .commit_pos(commit_pos), .commit_dest(commit_dest),
    .commit_value(commit_value),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .rs1_val(rs1_val), .rs2_val(rs2_val),
    .rs1_rob_pos(rs1_rob_pos), .rs2_rob_pos(rs2_rob_pos)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    update_valid = 1'b0;
    commit_valid = 1'b0;
    flush        = 1'b0;
  endtask

  task automatic rename(input logic [4:0] rd, input logic [3:0] pos);
    update_valid = 1'b1; update_rd = rd; update_pos = pos;
  endtask

  task automatic commit(input logic [4:0] rd, input logic [3:0] pos, input logic [31:0] v);
    commit_valid = 1'b1; commit_dest = rd; commit_pos = pos; commit_value = v;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; flush = 1'b0;
    update_valid = 1'b0; update_pos = '0; update_rd = '0;
    commit_valid = 1'b0; commit_pos = '0; commit_dest = '0; commit_value = '0;
    rs1_addr = 5'd5; rs2_addr = 5'd7;
    #2;
    check("reset_rs1_busy", rs1_busy, 0);
    check("reset_rs1_val", rs1_val, 0);
    check("reset_rs2_pos", rs2_rob_pos, 0);
    step();
    rst = 1'b0;

    // Rename x5 -> pos 3; own-rd read sees old mapping
    rename(5'd5, 4'd3);
    #1 check("rename_same_cycle_old", rs1_busy, 0);
    step(); idle();
    check("x5_busy", rs1_busy, 1);
    check("x5_pos", rs1_rob_pos, 3);
    commit(5'd5, 4'd3, 32'hDEADBEEF);
    #1 check("x5_fwd_busy", rs1_busy, 0);
    check("x5_fwd_val", rs1_val, 32'hDEADBEEF);
    step(); idle();
    check("x5_state_busy", rs1_busy, 0);
    check("x5_state_val", rs1_val, 32'hDEADBEEF);

    // Stale commit does not clear a newer rename
    rename(5'd7, 4'd2); step();
    rename(5'd7, 4'd9); step(); idle();
    commit(5'd7, 4'd2, 32'h11);
    #1 check("x7_nofwd_busy", rs2_busy, 1);
    check("x7_nofwd_val", rs2_val, 0);
    step(); idle();
    check("x7_val", rs2_val, 32'h11);
    check("x7_busy", rs2_busy, 1);
    check("x7_pos", rs2_rob_pos, 9);

    // Same-cycle commit and rename of x4
    rs1_addr = 5'd4;
    rename(5'd4, 4'd1); step(); idle();
    commit(5'd4, 4'd1, 32'h22);
    rename(5'd4, 4'd6);
    step(); idle();
    check("x4_busy", rs1_busy, 1);
    check("x4_pos", rs1_rob_pos, 6);
    check("x4_val", rs1_val, 32'h22);

    // Flush ignores commit, clears busy and tags, keeps values
    rs1_addr = 5'd1; rs2_addr = 5'd2;
    commit(5'd1, 4'd15, 32'hA1); step(); idle();
    rename(5'd1, 4'd0); step();
    rename(5'd2, 4'd1); step();
    rename(5'd3, 4'd2); step(); idle();
    flush = 1'b1;
    commit(5'd1, 4'd0, 32'h99);
    #1 check("flush_nofwd_busy", rs1_busy, 1);
    check("flush_nofwd_val", rs1_val, 32'hA1);
    step(); idle();
    check("flush_x1_busy", rs1_busy, 0);
    check("flush_x1_val", rs1_val, 32'hA1);
    check("flush_x1_pos", rs1_rob_pos, 0);
    check("flush_x2_busy", rs2_busy, 0);
    rs1_addr = 5'd3;
    #1 check("flush_x3_busy", rs1_busy, 0);

    // x0 is hardwired
    rs2_addr = 5'd0;
    commit(5'd0, 4'd5, 32'h55);
    rename(5'd0, 4'd5);
    #1 check("x0_busy_now", rs2_busy, 0);
    check("x0_val_now", rs2_val, 0);
    step(); idle();
    check("x0_busy", rs2_busy, 0);
    check("x0_val", rs2_val, 0);
    check("x0_pos", rs2_rob_pos, 0);

    // rdy low freezes state
    rs1_addr = 5'd9;
    rdy = 1'b0;
    commit(5'd9, 4'd0, 32'h33);
    rename(5'd9, 4'd4);
    step(); idle(); rdy = 1'b1;
    check("frozen_x9_val", rs1_val, 0);
    check("frozen_x9_busy", rs1_busy, 0);

    // Asynchronous reset between edges
    rs1_addr = 5'd7; rs2_addr = 5'd4;
    #1 check("pre_rst_x7_val", rs1_val, 32'h11);
    #1 rst = 1'b1;
    #1;
    check("rst_rs1_busy", rs1_busy, 0);
    check("rst_rs1_val", rs1_val, 0);
    check("rst_rs1_pos", rs1_rob_pos, 0);
    check("rst_rs2_busy", rs2_busy, 0);
    check("rst_rs2_val", rs2_val, 0);
    check("rst_rs2_pos", rs2_rob_pos, 0);
    rs1_addr = 5'd9;
    commit(5'd9, 4'd0, 32'h77);
    rename(5'd9, 4'd4);
    step();
    rst = 1'b0; idle();
    #1 check("rst_ignored_val", rs1_val, 0);
    check("rst_ignored_busy", rs1_busy, 0);
    commit(5'd9, 4'd0, 32'h33);
    step(); idle();
    check("post_rst_commit", rs1_val, 32'h33);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
